// File: rtl/vga_rx_monitor.sv
// vga_rx_monitor
//   Watches a TinyVGA-style stream (active-low syncs, 2-bit RGB), locks onto
//   its timing and reports the active-pixel coordinates. It also computes a
//   CRC-16-CCITT signature of every complete frame received while locked and
//   keeps a saturating count of timing errors.
//
// Parameters
//   H_TOTAL, V_TOTAL          clocks per line, lines per frame
//   H_ACT_START, V_ACT_START  first active clock / line, counted from the sync fall
//   H_ACTIVE, V_ACTIVE        active pixels per line, active lines per frame
//
// Ports
//   clk           pixel clock, one pixel per cycle
//   rst           synchronous, active-high reset
//   i_hsync       active-low horizontal sync
//   i_vsync       active-low vertical sync
//   i_red/green/blue  2-bit colour components
//   o_locked      high while the lock FSM is in LOCKED
//   o_hpos/o_vpos active-pixel coordinates (0 outside the active area)
//   o_pix_valid   the current cycle carries an active pixel
//   o_frame_done  one-cycle pulse when o_signature updates
//   o_signature   CRC of the last complete, error-free locked frame
//   o_err_count   saturating count of line and frame timing errors
module vga_rx_monitor #(
  parameter int H_TOTAL     = 800,
  parameter int V_TOTAL     = 525,
  parameter int H_ACT_START = 144,
  parameter int V_ACT_START = 35,
  parameter int H_ACTIVE    = 640,
  parameter int V_ACTIVE    = 480
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_hsync,
  input  logic       i_vsync,
  input  logic [1:0] i_red,
  input  logic [1:0] i_green,
  input  logic [1:0] i_blue,
  output logic       o_locked,
  output logic [9:0] o_hpos,
  output logic [9:0] o_vpos,
  output logic       o_pix_valid,
  output logic       o_frame_done,
  output logic [15:0] o_signature,
  output logic [7:0] o_err_count
);

  localparam logic [1:0] ST_SEARCH  = 2'd0;
  localparam logic [1:0] ST_ACQUIRE = 2'd1;
  localparam logic [1:0] ST_LOCKED  = 2'd2;

  localparam logic [10:0] H_TOTAL_W = 11'(H_TOTAL);
  localparam logic [9:0]  V_TOTAL_W = 10'(V_TOTAL);
  localparam logic [9:0]  H_ACT_LO  = 10'(H_ACT_START);
  localparam logic [9:0]  H_ACT_HI  = 10'(H_ACT_START + H_ACTIVE - 1);
  localparam logic [9:0]  V_ACT_LO  = 10'(V_ACT_START);
  localparam logic [9:0]  V_ACT_HI  = 10'(V_ACT_START + V_ACTIVE - 1);
  localparam logic [9:0]  CNT_MAX   = 10'd1023;

  // Six bits of one pixel, MSB first, folded into the CRC in a single cycle.
  function automatic logic [15:0] crc16_step6(input logic [15:0] crc_in,
                                              input logic [5:0]  sym);
    logic [15:0] c;
    c = crc_in;
    for (int i = 5; i >= 0; i--) begin
      c = {c[14:0], 1'b0} ^ (((c[15] ^ sym[i]) == 1'b1) ? 16'h1021 : 16'h0000);
    end
    return c;
  endfunction

  logic [1:0]  r_state;
  logic [1:0]  w_state_next;
  logic        r_armed;
  logic        r_hs_prev;
  logic        r_vs_prev;
  logic [9:0]  r_hcnt;
  logic [9:0]  r_lcnt;
  logic        r_hs_seen;
  logic        r_line_err_seen;
  logic [15:0] r_crc;
  logic [15:0] r_signature;
  logic        r_frame_done;
  logic [7:0]  r_err_count;

  logic        w_hs_fall;
  logic        w_vs_fall;
  logic [10:0] w_hcnt_plus1;
  logic        w_line_err;
  logic        w_frame_err;
  logic        w_hsync_lost;
  logic        w_h_active;
  logic        w_v_active;
  logic        w_pix_valid;
  logic [15:0] w_crc_next;

  // r_armed masks the first cycle after reset so a sync input that is already
  // low when reset drops is not mistaken for a falling edge.
  assign w_hs_fall = r_armed & r_hs_prev & ~i_hsync;
  assign w_vs_fall = r_armed & r_vs_prev & ~i_vsync;

  assign w_hcnt_plus1 = {1'b0, r_hcnt} + 11'd1;

  // The first hsync fall after reset or after hsync loss has no reference
  // line start, so its period is not checked.
  assign w_line_err  = w_hs_fall & r_hs_seen & (w_hcnt_plus1 != H_TOTAL_W);
  assign w_frame_err = w_vs_fall &
                       ((r_lcnt != V_TOTAL_W) | r_line_err_seen | w_line_err);

  // An hsync fall in the saturated cycle means the sync has just come back,
  // so it is not treated as a loss; this lets that same edge be acted upon.
  assign w_hsync_lost = (r_hcnt == CNT_MAX) & ~w_hs_fall;

  assign w_h_active  = (r_hcnt >= H_ACT_LO) & (r_hcnt <= H_ACT_HI);
  assign w_v_active  = (r_lcnt >= V_ACT_LO) & (r_lcnt <= V_ACT_HI);
  assign w_pix_valid = (r_state == ST_LOCKED) & w_h_active & w_v_active;

  assign w_crc_next = crc16_step6(r_crc, {i_red, i_green, i_blue});

  always_comb begin
    w_state_next = r_state;
    if (w_hsync_lost) begin
      w_state_next = ST_SEARCH;
    end else begin
      case (r_state)
        ST_SEARCH:  if (w_vs_fall) w_state_next = ST_ACQUIRE;
        ST_ACQUIRE: if (w_vs_fall && !w_frame_err) w_state_next = ST_LOCKED;
        ST_LOCKED:  if (w_line_err || w_frame_err) w_state_next = ST_ACQUIRE;
        default:    w_state_next = ST_SEARCH;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_SEARCH;
      r_armed   <= 1'b0;
      r_hs_prev <= 1'b1;
      r_vs_prev <= 1'b1;
    end else begin
      r_state   <= w_state_next;
      r_armed   <= 1'b1;
      r_hs_prev <= i_hsync;
      r_vs_prev <= i_vsync;
    end
  end

  // Line and frame counters; both saturate rather than wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hcnt <= 10'd0;
      r_lcnt <= 10'd0;
    end else begin
      if (w_hs_fall) begin
        r_hcnt <= 10'd0;
      end else if (r_hcnt != CNT_MAX) begin
        r_hcnt <= r_hcnt + 10'd1;
      end

      if (w_vs_fall) begin
        r_lcnt <= w_hs_fall ? 10'd1 : 10'd0;
      end else if (w_hs_fall && (r_lcnt != CNT_MAX)) begin
        r_lcnt <= r_lcnt + 10'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_hs_seen       <= 1'b0;
      r_line_err_seen <= 1'b0;
    end else begin
      if (w_hs_fall) begin
        r_hs_seen <= 1'b1;
      end else if (r_hcnt == CNT_MAX) begin
        r_hs_seen <= 1'b0;
      end

      // A line error in the vsync-fall cycle is already folded into that
      // cycle's frame error, so the flag can simply restart.
      if (w_vs_fall) begin
        r_line_err_seen <= 1'b0;
      end else if (w_line_err) begin
        r_line_err_seen <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_crc        <= 16'hFFFF;
      r_signature  <= 16'h0000;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      if (w_vs_fall) begin
        r_crc <= 16'hFFFF;
        if ((r_state == ST_LOCKED) && !w_frame_err) begin
          r_signature  <= r_crc;
          r_frame_done <= 1'b1;
        end
      end else if (w_pix_valid) begin
        r_crc <= w_crc_next;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_err_count <= 8'd0;
    end else if ((r_state != ST_SEARCH) && (w_line_err || w_frame_err) &&
                 (r_err_count != 8'hFF)) begin
      r_err_count <= r_err_count + 8'd1;
    end
  end

  assign o_locked     = (r_state == ST_LOCKED);
  assign o_pix_valid  = w_pix_valid;
  assign o_hpos       = w_pix_valid ? (r_hcnt - H_ACT_LO) : 10'd0;
  assign o_vpos       = w_pix_valid ? (r_lcnt - V_ACT_LO) : 10'd0;
  assign o_frame_done = r_frame_done;
  assign o_signature  = r_signature;
  assign o_err_count  = r_err_count;

endmodule

// File: tb/tb_vga_rx_monitor.sv
// tb_vga_rx_monitor
//   Directed bench for vga_rx_monitor. A small reference timing generator
//   produces frames with a reduced geometry (100 clocks x 30 lines) so the run
//   stays short; the hsync-loss and saturation cases use the fixed 1023 / 255
//   limits of the design.
module tb_vga_rx_monitor;

  localparam int HT  = 100;
  localparam int VT  = 30;
  localparam int HS  = 18;
  localparam int VS  = 5;
  localparam int HA  = 80;
  localparam int VA  = 20;
  localparam int HSW = 10;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_hsync;
  logic        i_vsync;
  logic [1:0]  i_red;
  logic [1:0]  i_green;
  logic [1:0]  i_blue;
  logic        o_locked;
  logic [9:0]  o_hpos;
  logic [9:0]  o_vpos;
  logic        o_pix_valid;
  logic        o_frame_done;
  logic [15:0] o_signature;
  logic [7:0]  o_err_count;

  vga_rx_monitor #(
    .H_TOTAL(HT), .V_TOTAL(VT), .H_ACT_START(HS), .V_ACT_START(VS),
    .H_ACTIVE(HA), .V_ACTIVE(VA)
  ) dut (
    .clk(clk), .rst(rst), .i_hsync(i_hsync), .i_vsync(i_vsync),
    .i_red(i_red), .i_green(i_green), .i_blue(i_blue),
    .o_locked(o_locked), .o_hpos(o_hpos), .o_vpos(o_vpos),
    .o_pix_valid(o_pix_valid), .o_frame_done(o_frame_done),
    .o_signature(o_signature), .o_err_count(o_err_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int g_ln;
  int g_h;
  int g_short;
  bit g_pat;
  logic [15:0] crc_zero;
  logic [15:0] crc_pat;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [5:0] pat(input int x, input int y);
    int v;
    v = x * 5 + y * 11 + 7;
    return v[5:0];
  endfunction

  function automatic logic [15:0] crc_sym(input logic [15:0] c_in, input logic [5:0] s);
    logic [15:0] c;
    c = c_in;
    for (int b = 5; b >= 0; b--) begin
      if ((c[15] ^ s[b]) == 1'b1) c = (c << 1) ^ 16'h1021;
      else                        c = c << 1;
    end
    return c;
  endfunction

  function automatic logic [15:0] frame_crc(input bit use_pat);
    logic [15:0] c;
    c = 16'hFFFF;
    for (int y = 0; y < VA; y++)
      for (int x = 0; x < HA; x++)
        c = crc_sym(c, use_pat ? pat(x, y) : 6'd0);
    return c;
  endfunction

  // Colour driven at generator clock h belongs to the pixel the monitor sees
  // one cycle later, i.e. hcnt = h-1 on line count ln+1.
  task automatic drive_cur();
    int x;
    int y;
    logic [5:0] p;
    i_hsync = (g_h < HSW) ? 1'b0 : 1'b1;
    i_vsync = (g_ln < 2) ? 1'b0 : 1'b1;
    x = g_h - 1 - HS;
    y = g_ln + 1 - VS;
    if (g_pat && g_h >= 1 && x >= 0 && x < HA && y >= 0 && y < VA) begin
      p = pat(x, y);
      i_red = p[5:4]; i_green = p[3:2]; i_blue = p[1:0];
    end else begin
      i_red = 2'd0; i_green = 2'd0; i_blue = 2'd0;
    end
  endtask

  task automatic step();
    int len;
    drive_cur();
    @(posedge clk);
    #1;
    len = (g_ln == g_short) ? HT - 1 : HT;
    g_h++;
    if (g_h >= len) begin
      g_h = 0;
      g_ln++;
      if (g_ln >= VT) g_ln = 0;
    end
  endtask

  // Advance until generator position (ln,h) has been clocked into the DUT.
  task automatic run_until(input int ln, input int h);
    bit hit;
    hit = 1'b0;
    for (int n = 0; n < 3 * HT * VT && !hit; n++) begin
      hit = (g_ln == ln) && (g_h == h);
      step();
    end
    check("reach_position", 32'(hit), 32'd1);
  endtask

  task automatic idle(input int n, input logic hs, input logic vs);
    for (int k = 0; k < n; k++) begin
      i_hsync = hs; i_vsync = vs;
      i_red = 2'd0; i_green = 2'd0; i_blue = 2'd0;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    $display("[%0t] %s: reset-value checks", $time, tag);
    check({tag, "_locked"}, 32'(o_locked), 32'd0);
    check({tag, "_sig"},    32'(o_signature), 32'd0);
    check({tag, "_err"},    32'(o_err_count), 32'd0);
    check({tag, "_fd"},     32'(o_frame_done), 32'd0);
    check({tag, "_pv"},     32'(o_pix_valid), 32'd0);
    check({tag, "_hpos"},   32'(o_hpos), 32'd0);
    check({tag, "_vpos"},   32'(o_vpos), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    i_hsync = 1'b1; i_vsync = 1'b1;
    i_red = 2'd0; i_green = 2'd0; i_blue = 2'd0;
    g_ln = 0; g_h = 0; g_short = -1; g_pat = 1'b0;
    crc_zero = frame_crc(1'b0);
    crc_pat  = frame_crc(1'b1);

    // Reset state
    idle(3, 1'b1, 1'b1);
    check_reset_outputs("reset");
    rst = 1'b0;
    idle(4, 1'b1, 1'b1);

    // Three nominal frames, frame 2 all-zero pixels
    run_until(0, 0);
    $display("[%0t] vsync fall 1", $time);
    check("lock_after_1st", 32'(o_locked), 32'd0);
    run_until(0, 0);
    $display("[%0t] vsync fall 2", $time);
    check("lock_after_2nd", 32'(o_locked), 32'd1);
    check("fd_at_2nd", 32'(o_frame_done), 32'd0);

    run_until(4, 17);
    check("pv_before_first", 32'(o_pix_valid), 32'd0);
    check("hpos_before_first", 32'(o_hpos), 32'd0);
    run_until(4, 18);
    $display("[%0t] first active pixel", $time);
    check("pv_first", 32'(o_pix_valid), 32'd1);
    check("hpos_first", 32'(o_hpos), 32'd0);
    check("vpos_first", 32'(o_vpos), 32'd0);
    run_until(4, 57);
    check("hpos_mid", 32'(o_hpos), 32'd39);
    check("vpos_mid", 32'(o_vpos), 32'd0);
    run_until(23, 97);
    $display("[%0t] last active pixel", $time);
    check("pv_last", 32'(o_pix_valid), 32'd1);
    check("hpos_last", 32'(o_hpos), 32'd79);
    check("vpos_last", 32'(o_vpos), 32'd19);
    run_until(23, 98);
    check("pv_after_last", 32'(o_pix_valid), 32'd0);
    check("hpos_after_last", 32'(o_hpos), 32'd0);
    check("vpos_after_last", 32'(o_vpos), 32'd0);
    run_until(24, 18);
    check("pv_below_area", 32'(o_pix_valid), 32'd0);
    g_pat = 1'b1;

    run_until(0, 0);
    $display("[%0t] vsync fall 3 (zero frame signature)", $time);
    check("fd_at_3rd", 32'(o_frame_done), 32'd1);
    check("sig_zero", 32'(o_signature), 32'(crc_zero));
    check("err_nominal", 32'(o_err_count), 32'd0);
    check("lock_at_3rd", 32'(o_locked), 32'd1);
    step();
    check("fd_one_cycle", 32'(o_frame_done), 32'd0);

    run_until(0, 0);
    $display("[%0t] vsync fall 4 (pattern frame signature)", $time);
    check("fd_at_4th", 32'(o_frame_done), 32'd1);
    check("sig_pattern", 32'(o_signature), 32'(crc_pat));

    // One short line while locked
    g_short = 10;
    run_until(11, 0);
    $display("[%0t] short line end", $time);
    check("err_short_line", 32'(o_err_count), 32'd1);
    check("unlock_short_line", 32'(o_locked), 32'd0);
    g_short = -1;
    run_until(0, 0);
    $display("[%0t] vsync after short line", $time);
    check("fd_after_short", 32'(o_frame_done), 32'd0);
    check("lock_after_short", 32'(o_locked), 32'd0);
    check("err_frame_after_short", 32'(o_err_count), 32'd2);
    run_until(0, 0);
    $display("[%0t] relock vsync", $time);
    check("relock", 32'(o_locked), 32'd1);
    check("fd_at_relock", 32'(o_frame_done), 32'd0);

    // Hsync held high
    idle(1000, 1'b1, 1'b1);
    check("lock_before_loss", 32'(o_locked), 32'd1);
    idle(100, 1'b1, 1'b1);
    $display("[%0t] hsync loss", $time);
    check("lock_after_loss", 32'(o_locked), 32'd0);
    check("hcnt_saturated", 32'(dut.r_hcnt), 32'd1023);
    check("err_after_loss", 32'(o_err_count), 32'd2);

    // 300 short-line error events (the first fall after loss is exempt)
    for (int i = 0; i < 300; i++) begin
      for (int c = 0; c < 10; c++)
        idle(1, (c < 2) ? 1'b0 : 1'b1, (i == 0 && c < 2) ? 1'b0 : 1'b1);
      if (i == 99) begin
        $display("[%0t] 99 error events", $time);
        check("err_partial", 32'(o_err_count), 32'd101);
      end
    end
    $display("[%0t] 299 error events", $time);
    check("err_saturated", 32'(o_err_count), 32'd255);
    check("lock_during_errors", 32'(o_locked), 32'd0);

    // Relock, then reset mid-frame
    g_ln = 0; g_h = 0;
    run_until(0, 0);
    check("lock_reacq_1", 32'(o_locked), 32'd0);
    run_until(0, 0);
    check("lock_reacq_2", 32'(o_locked), 32'd1);
    run_until(10, 50);
    check("pv_before_reset", 32'(o_pix_valid), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_reset_outputs("midframe_reset");
    run_until(0, 0);
    $display("[%0t] post-reset vsync 1", $time);
    check("post_rst_lock_1", 32'(o_locked), 32'd0);
    check("post_rst_fd_1", 32'(o_frame_done), 32'd0);
    run_until(0, 0);
    $display("[%0t] post-reset vsync 2", $time);
    check("post_rst_lock_2", 32'(o_locked), 32'd1);
    check("post_rst_fd_2", 32'(o_frame_done), 32'd0);
    run_until(0, 0);
    $display("[%0t] post-reset vsync 3", $time);
    check("post_rst_fd_3", 32'(o_frame_done), 32'd1);
    check("post_rst_sig", 32'(o_signature), 32'(crc_pat));
    check("post_rst_err", 32'(o_err_count), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
